dcache_flush_unit: RTL and testbench
====================================

# dcache_flush_unit

Write-back data-cache flush engine: the responder to the core flush controller's `flush_dcache` request. On request it walks every set and way of the cache arrays, writes back each valid dirty line to memory, and invalidates every line. It then returns a single-cycle acknowledge that releases the controller's fence/halt. It sits inside the write-back dcache, between the cache array arbiter and the memory write-back port.

## Interface
Parameters:
- `NR_SETS`, 256, number of sets; power of two, ≥2.
- `NR_WAYS`, 8, number of ways; ≥1.
- `TAG_W`, 44, tag width.
- `LINE_W`, 128, line width in bits; power of two, ≥8.
- Derived: `INDEX_W`=$clog2(NR_SETS), `OFFSET_W`=$clog2(LINE_W/8), `ADDR_W`=TAG_W+INDEX_W+OFFSET_W.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `flush_i` in 1: flush request level from the controller; held until ack.
- `flush_ack_o` out 1: one-cycle pulse when the flush is complete.
- `busy_o` out 1: high in every state except IDLE.
- `arr_req_o` out 1: requests exclusive array ownership.
- `arr_gnt_i` in 1: ownership granted; held until `arr_req_o` drops.
- `arr_rd_o` out 1: read strobe for set `arr_idx_o`.
- `arr_idx_o` out INDEX_W: set index for reads and invalidates.
- `arr_valid_i` in NR_WAYS: valid bits for the set read.
- `arr_dirty_i` in NR_WAYS: dirty bits for the set read.
- `arr_tag_i` in NR_WAYS*TAG_W: tags; way w occupies bits [w*TAG_W +: TAG_W].
- `arr_data_i` in NR_WAYS*LINE_W: line data, packed the same way.
- `arr_inv_o` out 1: clears valid and dirty for the ways in `arr_way_mask_o` at `arr_idx_o`.
- `arr_way_mask_o` out NR_WAYS: ways to invalidate.
- `wb_req_o` out 1: write-back request.
- `wb_gnt_i` in 1: write-back accepted.
- `wb_addr_o` out ADDR_W: {tag, index, OFFSET_W'0}.
- `wb_data_o` out LINE_W: line to write.
- `wb_done_i` in 1: write completion.

Array contract: `arr_*_i` are valid the cycle after `arr_rd_o`. They hold until the next `arr_rd_o` or `arr_inv_o`.

## Operation
- Registers: state, set counter `idx_q` (INDEX_W), pending mask `pend_q` (NR_WAYS), valid mask `vld_q` (NR_WAYS), current way `way_q`.
- IDLE: all outputs 0. When `flush_i`=1, go to ARB.
- ARB: `arr_req_o`=1. `arr_req_o` stays 1 through ACK. On `arr_gnt_i`, set `idx_q`=0 and go to RD.
- RD: `arr_rd_o`=1, `arr_idx_o`=`idx_q`. Go to CHK.
- CHK: load `pend_q` = `arr_valid_i` & `arr_dirty_i` and `vld_q` = `arr_valid_i`. Dirty bits on invalid ways are ignored.
  - If the pending mask is nonzero: `way_q` = lowest set bit; go to WB.
  - Else, if any valid way: go to INV.
  - Else: go to NEXT.
- WB: `wb_req_o`=1. `wb_addr_o`/`wb_data_o` come from way `way_q` and are held stable while waiting. On `wb_gnt_i`, go to WAIT.
- WAIT: on `wb_done_i`, clear bit `way_q` in `pend_q`.
  - If pending bits remain: `way_q` = next lowest; go to WB.
  - Else: go to INV.
- INV: `arr_inv_o`=1, `arr_way_mask_o`=`vld_q`, `arr_idx_o`=`idx_q`. Go to NEXT.
- NEXT: this is a state, not a combinational step.
  - If `idx_q`=NR_SETS-1: go to ACK.
  - Else: increment `idx_q` and go to RD.
- ACK: `flush_ack_o`=1 for exactly one cycle. Go to DRAIN.
- DRAIN: `arr_req_o`=0. Return to IDLE once `flush_i`=0.
- `flush_i` dropping mid-flush does not abort; the flush completes and ack is still pulsed.
- `wb_done_i` outside WAIT is ignored. At most one write-back is outstanding.
- `idx_q` never wraps during a flush; the last set index is NR_SETS-1.

## Timing
- Reset (async, any state): state=IDLE, all counters and masks 0, every output 0.
- Request to first `arr_req_o`: 1 cycle (registered state).
- Per set cost:
  - no valid ways: 3 cycles (RD, CHK, NEXT);
  - valid but clean: 4 cycles (RD, CHK, INV, NEXT);
  - each dirty way adds ≥2 cycles (WB + WAIT, minimum, with same-cycle gnt/done).
- Empty cache with immediate grant: `flush_ack_o` asserts 2+3*NR_SETS cycles after `flush_i` is sampled high.
- Write-backs within a set are issued in ascending way order. The INV for a set follows the last `wb_done_i` of that set.
- Because of DRAIN, the controller's registered flush deasserting one cycle after ack cannot retrigger a flush.

## Test plan
Unless noted, NR_SETS=4, NR_WAYS=2, TAG_W=8, LINE_W=32.
- Empty cache, `arr_gnt_i` tied high, `flush_i` raised:
  - exactly 4 `arr_rd_o` pulses, idx 0,1,2,3;
  - no `wb_req_o` and no `arr_inv_o`;
  - `flush_ack_o` one cycle wide, 14 cycles after `flush_i`.
- Set 2, way 1: valid, dirty, tag 0xA5, data 0xDEADBEEF:
  - one write-back with `wb_addr_o`=0x0A58, `wb_data_o`=0xDEADBEEF;
  - then `arr_inv_o` with idx 2, mask 2'b10.
- Set 0, both ways valid+dirty; `wb_gnt_i` stalled 5 cycles:
  - way 0 is written before way 1;
  - address and data stay stable during the stall;
  - a single INV with mask 2'b11 follows the second done.
- `flush_i` held high 3 cycles after ack: no second `arr_req_o`. `flush_i` raised again after going low: a full new walk.
- `rst_ni` asserted during WAIT:
  - outputs 0 immediately (async);
  - after release, no `wb_req_o` until a new `flush_i`;
  - a late `wb_done_i` is ignored.
- Valid clean line in set 3: `arr_inv_o` mask 2'b01, no write-back. Dirty bit on an invalid way: no write-back.

Source files
------------

// File: rtl/dcache_flush_unit.sv
// Write-back dcache flush engine: walks every set, writes back valid dirty ways in
// ascending order, invalidates the valid ways, then pulses flush_ack_o once.
module dcache_flush_unit #(
   parameter int NR_SETS  = 256,
   parameter int NR_WAYS  = 8,
   parameter int TAG_W    = 44,
   parameter int LINE_W   = 128,
   parameter int INDEX_W  = $clog2(NR_SETS),
   parameter int OFFSET_W = $clog2(LINE_W / 8),
   parameter int ADDR_W   = TAG_W + INDEX_W + OFFSET_W
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   output logic                      flush_ack_o,
   output logic                      busy_o,
   output logic                      arr_req_o,
   input  logic                      arr_gnt_i,
   output logic                      arr_rd_o,
   output logic [INDEX_W-1:0]        arr_idx_o,
   input  logic [NR_WAYS-1:0]        arr_valid_i,
   input  logic [NR_WAYS-1:0]        arr_dirty_i,
   input  logic [NR_WAYS*TAG_W-1:0]  arr_tag_i,
   input  logic [NR_WAYS*LINE_W-1:0] arr_data_i,
   output logic                      arr_inv_o,
   output logic [NR_WAYS-1:0]        arr_way_mask_o,
   output logic                      wb_req_o,
   input  logic                      wb_gnt_i,
   output logic [ADDR_W-1:0]         wb_addr_o,
   output logic [LINE_W-1:0]         wb_data_o,
   input  logic                      wb_done_i
);

   localparam int WAY_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_ARB, S_RD, S_CHK, S_WB, S_WAIT, S_INV, S_NEXT, S_ACK, S_DRAIN
   } state_e;

   state_e             state_q, state_d;
   logic [INDEX_W-1:0] idx_q, idx_d;
   logic [NR_WAYS-1:0] pend_q, pend_d;
   logic [NR_WAYS-1:0] vld_q, vld_d;
   logic [WAY_W-1:0]   way_q, way_d;

   logic                busy_d, arr_req_d, arr_rd_d, arr_inv_d, wb_req_d, ack_d;
   logic [INDEX_W-1:0]  arr_idx_d;
   logic [NR_WAYS-1:0]  mask_d;
   logic [ADDR_W-1:0]   wb_addr_d;
   logic [LINE_W-1:0]   wb_data_d;

   logic [TAG_W-1:0]  tag_way  [NR_WAYS];
   logic [LINE_W-1:0] data_way [NR_WAYS];

   for (genvar gi = 0; gi < NR_WAYS; gi++) begin : g_way
      assign tag_way[gi]  = arr_tag_i[gi*TAG_W +: TAG_W];
      assign data_way[gi] = arr_data_i[gi*LINE_W +: LINE_W];
   end

   function automatic logic [WAY_W-1:0] lowest_way(input logic [NR_WAYS-1:0] m);
      lowest_way = '0;
      for (int i = NR_WAYS - 1; i >= 0; i--) begin
         if (m[i]) lowest_way = WAY_W'(i);
      end
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pend_d  = pend_q;
      vld_d   = vld_q;
      way_d   = way_q;
      case (state_q)
         S_IDLE:  if (flush_i) state_d = S_ARB;
         S_ARB: begin
            if (arr_gnt_i) begin
               idx_d   = '0;
               state_d = S_RD;
            end
         end
         S_RD:    state_d = S_CHK;
         S_CHK: begin
            // dirty bits on invalid ways are meaningless and must not trigger a write-back
            pend_d = arr_valid_i & arr_dirty_i;
            vld_d  = arr_valid_i;
            if (|pend_d) begin
               way_d   = lowest_way(pend_d);
               state_d = S_WB;
            end else if (|arr_valid_i) begin
               state_d = S_INV;
            end else begin
               state_d = S_NEXT;
            end
         end
         S_WB:    if (wb_gnt_i) state_d = S_WAIT;
         S_WAIT: begin
            if (wb_done_i) begin
               pend_d = pend_q & ~(NR_WAYS'(1) << way_q);
               if (|pend_d) begin
                  way_d   = lowest_way(pend_d);
                  state_d = S_WB;
               end else begin
                  state_d = S_INV;
               end
            end
         end
         S_INV:   state_d = S_NEXT;
         S_NEXT: begin
            if (idx_q == INDEX_W'(NR_SETS - 1)) begin
               state_d = S_ACK;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_RD;
            end
         end
         S_ACK:   state_d = S_DRAIN;
         S_DRAIN: if (!flush_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they leave the flops with the state.
      busy_d    = (state_d != S_IDLE);
      arr_req_d = (state_d != S_IDLE) && (state_d != S_DRAIN);
      arr_rd_d  = (state_d == S_RD);
      arr_inv_d = (state_d == S_INV);
      wb_req_d  = (state_d == S_WB);
      ack_d     = (state_d == S_ACK);
      arr_idx_d = (state_d == S_RD || state_d == S_INV) ? idx_d : '0;
      mask_d    = (state_d == S_INV) ? vld_d : '0;
      wb_addr_d = '0;
      wb_data_d = '0;
      if (state_d == S_WB) begin
         wb_addr_d = {tag_way[way_d], idx_d, {OFFSET_W{1'b0}}};
         wb_data_d = data_way[way_d];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         pend_q         <= '0;
         vld_q          <= '0;
         way_q          <= '0;
         busy_o         <= 1'b0;
         arr_req_o      <= 1'b0;
         arr_rd_o       <= 1'b0;
         arr_idx_o      <= '0;
         arr_inv_o      <= 1'b0;
         arr_way_mask_o <= '0;
         wb_req_o       <= 1'b0;
         wb_addr_o      <= '0;
         wb_data_o      <= '0;
         flush_ack_o    <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         pend_q         <= pend_d;
         vld_q          <= vld_d;
         way_q          <= way_d;
         busy_o         <= busy_d;
         arr_req_o      <= arr_req_d;
         arr_rd_o       <= arr_rd_d;
         arr_idx_o      <= arr_idx_d;
         arr_inv_o      <= arr_inv_d;
         arr_way_mask_o <= mask_d;
         wb_req_o       <= wb_req_d;
         wb_addr_o      <= wb_addr_d;
         wb_data_o      <= wb_data_d;
         flush_ack_o    <= ack_d;
      end
   end

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Directed bench for dcache_flush_unit: a cache-array model and write-back responder
// on the falling edge, single-line vectors from a table, plus multi-cycle sequences.
module tb_dcache_flush_unit;

   localparam int NS = 4, NW = 2, TW = 8, LW = 32, IW = 2, AW = 12;

   logic            clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
   logic            flush_ack_o, busy_o, arr_req_o, arr_rd_o, arr_inv_o, wb_req_o;
   logic            arr_gnt_i = 1'b0, wb_gnt_i = 1'b0, wb_done_i = 1'b0;
   logic [IW-1:0]   arr_idx_o;
   logic [NW-1:0]   arr_valid_i = '0, arr_dirty_i = '0, arr_way_mask_o;
   logic [NW*TW-1:0] arr_tag_i = '0;
   logic [NW*LW-1:0] arr_data_i = '0;
   logic [AW-1:0]   wb_addr_o;
   logic [LW-1:0]   wb_data_o;

   dcache_flush_unit #(.NR_SETS(NS), .NR_WAYS(NW), .TAG_W(TW), .LINE_W(LW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
      .busy_o(busy_o), .arr_req_o(arr_req_o), .arr_gnt_i(arr_gnt_i), .arr_rd_o(arr_rd_o),
      .arr_idx_o(arr_idx_o), .arr_valid_i(arr_valid_i), .arr_dirty_i(arr_dirty_i),
      .arr_tag_i(arr_tag_i), .arr_data_i(arr_data_i), .arr_inv_o(arr_inv_o),
      .arr_way_mask_o(arr_way_mask_o), .wb_req_o(wb_req_o), .wb_gnt_i(wb_gnt_i),
      .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_done_i(wb_done_i));

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // cache contents, owned by the monitor; the main sequence edits it through cmd_*
   logic          model_v [NS][NW];
   logic          model_d [NS][NW];
   logic [TW-1:0] model_tag [NS][NW];
   logic [LW-1:0] model_data [NS][NW];
   int cmd_seq = 0, cmd_done = 0, cmd_op = 0, cmd_set = 0, cmd_way = 0;
   logic cmd_v = 0, cmd_d = 0;
   logic [TW-1:0] cmd_tag = '0;
   logic [LW-1:0] cmd_data = '0;

   int gnt_delay = 0;
   bit done_hold = 0;
   bit done_pend = 0, wb_prev = 0, req_prev = 0;
   int stall = 0, unstable = 0, ack_cnt = 0, req_rise = 0, last_done_cyc = 0;
   logic [AW-1:0] held_addr = '0;
   logic [LW-1:0] held_data = '0;
   logic [AW-1:0] wb_addr_q [$];
   logic [LW-1:0] wb_data_q [$];
   logic [IW-1:0] rd_idx_q [$];
   logic [IW-1:0] inv_idx_q [$];
   logic [NW-1:0] inv_mask_q [$];
   int            inv_cyc_q [$];

   always @(negedge clk_i) begin
      if (cmd_seq != cmd_done) begin
         if (cmd_op == 0) begin
            for (int s = 0; s < NS; s++)
               for (int w = 0; w < NW; w++) begin
                  model_v[s][w] = 0; model_d[s][w] = 0;
                  model_tag[s][w] = '0; model_data[s][w] = '0;
               end
         end else begin
            model_v[cmd_set][cmd_way]    = cmd_v;
            model_d[cmd_set][cmd_way]    = cmd_d;
            model_tag[cmd_set][cmd_way]  = cmd_tag;
            model_data[cmd_set][cmd_way] = cmd_data;
         end
         cmd_done = cmd_seq;
      end
      if (arr_rd_o) begin
         rd_idx_q.push_back(arr_idx_o);
         for (int w = 0; w < NW; w++) begin
            arr_valid_i[w] = model_v[arr_idx_o][w];
            arr_dirty_i[w] = model_d[arr_idx_o][w];
            arr_tag_i[w*TW +: TW]  = model_tag[arr_idx_o][w];
            arr_data_i[w*LW +: LW] = model_data[arr_idx_o][w];
         end
      end
      if (arr_inv_o) begin
         inv_idx_q.push_back(arr_idx_o);
         inv_mask_q.push_back(arr_way_mask_o);
         inv_cyc_q.push_back(cyc);
         $display("[TB] cyc %0d inv idx=%0d mask=%b", cyc, arr_idx_o, arr_way_mask_o);
         for (int w = 0; w < NW; w++)
            if (arr_way_mask_o[w]) begin
               model_v[arr_idx_o][w] = 0; model_d[arr_idx_o][w] = 0;
            end
      end
      if (flush_ack_o) begin
         ack_cnt++;
         $display("[TB] cyc %0d flush ack", cyc);
      end
      if (arr_req_o && !req_prev) req_rise++;
      req_prev = arr_req_o;
      wb_gnt_i  = 1'b0;
      wb_done_i = 1'b0;
      if (wb_req_o) begin
         if (wb_prev && (wb_addr_o !== held_addr || wb_data_o !== held_data)) unstable++;
         held_addr = wb_addr_o;
         held_data = wb_data_o;
         if (stall >= gnt_delay) begin
            wb_gnt_i = 1'b1;
            done_pend = 1;
            stall = 0;
            wb_addr_q.push_back(wb_addr_o);
            wb_data_q.push_back(wb_data_o);
            $display("[TB] cyc %0d write-back addr=%h data=%h", cyc, wb_addr_o, wb_data_o);
         end else begin
            stall++;
         end
      end else if (done_pend && !done_hold) begin
         wb_done_i = 1'b1;
         done_pend = 0;
         last_done_cyc = cyc;
      end
      wb_prev = wb_req_o;
   end

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      outs = {10'd0, flush_ack_o, busy_o, arr_req_o, arr_rd_o, arr_idx_o, arr_inv_o,
              arr_way_mask_o, wb_req_o, wb_addr_o, wb_data_o};
   endfunction

   task automatic model_cmd(input int op, input int s, input int w, input logic v,
                            input logic d, input logic [TW-1:0] t, input logic [LW-1:0] dat);
      cmd_op = op; cmd_set = s; cmd_way = w; cmd_v = v; cmd_d = d; cmd_tag = t; cmd_data = dat;
      cmd_seq++;
      @(negedge clk_i);
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_flush(input int hold_after, output int lat);
      int c0;
      bit got;
      @(posedge clk_i); #1;
      flush_i = 1'b1;
      c0 = cyc;
      got = 0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clk_i);
         if (flush_ack_o) got = 1;
      end
      chk("ack_seen", got, 1);
      lat = got ? cyc - c0 : -1;
      repeat (hold_after + 1) @(posedge clk_i);
      #1 flush_i = 1'b0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk_i);
         if (!busy_o) got = 1;
      end
      chk("back_to_idle", got, 1);
   endtask

   typedef struct {
      int s_idx; int way_n; logic v; logic d; logic [TW-1:0] tag; logic [LW-1:0] data;
      int exp_wb; logic [AW-1:0] exp_addr; int exp_inv; logic [IW-1:0] exp_idx; logic [NW-1:0] exp_mask;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int lat, b_wb, b_inv, b_rd, b_ack, b_rise, b_uns;
      bit got;
      vecs[0] = '{2, 1, 1'b1, 1'b1, 8'hA5, 32'hDEADBEEF, 1, 12'hA58, 1, 2'd2, 2'b10};
      vecs[1] = '{3, 0, 1'b1, 1'b0, 8'h3C, 32'h0000_0000, 0, 12'h000, 1, 2'd3, 2'b01};
      vecs[2] = '{1, 0, 1'b0, 1'b1, 8'h11, 32'h0000_0055, 0, 12'h000, 0, 2'd0, 2'b00};
      vecs[3] = '{0, 0, 1'b1, 1'b1, 8'hFF, 32'h12345678, 1, 12'hFF0, 1, 2'd0, 2'b01};
      vecs[4] = '{3, 1, 1'b1, 1'b1, 8'h01, 32'hCAFEF00D, 1, 12'h01C, 1, 2'd3, 2'b10};

      repeat (3) @(posedge clk_i);
      #1 chk("reset_outputs", outs(), 64'd0);
      rst_ni = 1'b1;
      arr_gnt_i = 1'b1;
      model_cmd(0, 0, 0, 0, 0, '0, '0);
      chk("idle_outputs", outs(), 64'd0);

      // empty cache walk
      b_rd = rd_idx_q.size(); b_wb = wb_addr_q.size(); b_inv = inv_idx_q.size(); b_ack = ack_cnt;
      do_flush(0, lat);
      chk("empty_ack_latency", lat, 14);
      chk("empty_ack_width", ack_cnt - b_ack, 1);
      chk("empty_rd_count", rd_idx_q.size() - b_rd, 4);
      for (int i = 0; i < 4; i++)
         if (rd_idx_q.size() > b_rd + i) chk($sformatf("empty_rd_idx%0d", i), rd_idx_q[b_rd+i], i);
      chk("empty_wb_count", wb_addr_q.size() - b_wb, 0);
      chk("empty_inv_count", inv_idx_q.size() - b_inv, 0);

      // single-line vectors
      foreach (vecs[k]) begin
         model_cmd(0, 0, 0, 0, 0, '0, '0);
         model_cmd(1, vecs[k].s_idx, vecs[k].way_n, vecs[k].v, vecs[k].d, vecs[k].tag, vecs[k].data);
         b_wb = wb_addr_q.size(); b_inv = inv_idx_q.size(); b_ack = ack_cnt;
         do_flush(0, lat);
         chk($sformatf("v%0d_wb_count", k), wb_addr_q.size() - b_wb, vecs[k].exp_wb);
         if (vecs[k].exp_wb > 0 && wb_addr_q.size() > b_wb) begin
            chk($sformatf("v%0d_wb_addr", k), wb_addr_q[b_wb], vecs[k].exp_addr);
            chk($sformatf("v%0d_wb_data", k), wb_data_q[b_wb], vecs[k].data);
         end
         chk($sformatf("v%0d_inv_count", k), inv_idx_q.size() - b_inv, vecs[k].exp_inv);
         if (vecs[k].exp_inv > 0 && inv_idx_q.size() > b_inv) begin
            chk($sformatf("v%0d_inv_idx", k), inv_idx_q[b_inv], vecs[k].exp_idx);
            chk($sformatf("v%0d_inv_mask", k), inv_mask_q[b_inv], vecs[k].exp_mask);
         end
         chk($sformatf("v%0d_ack_count", k), ack_cnt - b_ack, 1);
         chk($sformatf("v%0d_line_invalid", k), model_v[vecs[k].s_idx][vecs[k].way_n], 0);
      end

      // two dirty ways in set 0 with a stalled grant
      model_cmd(0, 0, 0, 0, 0, '0, '0);
      model_cmd(1, 0, 0, 1, 1, 8'h11, 32'h1111_1111);
      model_cmd(1, 0, 1, 1, 1, 8'h22, 32'h2222_2222);
      gnt_delay = 5;
      b_wb = wb_addr_q.size(); b_inv = inv_idx_q.size(); b_uns = unstable;
      do_flush(0, lat);
      gnt_delay = 0;
      chk("stall_wb_count", wb_addr_q.size() - b_wb, 2);
      if (wb_addr_q.size() >= b_wb + 2) begin
         chk("stall_first_addr", wb_addr_q[b_wb], 12'h110);
         chk("stall_first_data", wb_data_q[b_wb], 32'h1111_1111);
         chk("stall_second_addr", wb_addr_q[b_wb+1], 12'h220);
         chk("stall_second_data", wb_data_q[b_wb+1], 32'h2222_2222);
      end
      chk("stall_stable", unstable - b_uns, 0);
      chk("stall_inv_count", inv_idx_q.size() - b_inv, 1);
      if (inv_idx_q.size() > b_inv) begin
         chk("stall_inv_mask", inv_mask_q[b_inv], 2'b11);
         chk("stall_inv_after_done", inv_cyc_q[b_inv] > last_done_cyc, 1);
      end

      // flush held after ack must not retrigger; a fresh request walks again
      model_cmd(0, 0, 0, 0, 0, '0, '0);
      b_rise = req_rise;
      do_flush(3, lat);
      chk("hold_single_req", req_rise - b_rise, 1);
      b_rd = rd_idx_q.size(); b_ack = ack_cnt;
      do_flush(0, lat);
      chk("rewalk_rd_count", rd_idx_q.size() - b_rd, 4);
      chk("rewalk_ack", ack_cnt - b_ack, 1);

      // asynchronous reset while waiting for write completion
      model_cmd(1, 1, 0, 1, 1, 8'h22, 32'hABCD_0123);
      done_hold = 1;
      b_wb = wb_addr_q.size();
      @(posedge clk_i); #1 flush_i = 1'b1;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk_i);
         if (wb_addr_q.size() > b_wb) got = 1;
      end
      chk("rst_wb_reached", got, 1);
      @(posedge clk_i); #2;
      rst_ni = 1'b0;
      flush_i = 1'b0;
      #1 chk("rst_async_outputs", outs(), 64'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      done_hold = 0;
      b_wb = wb_addr_q.size(); b_rise = req_rise;
      repeat (10) @(negedge clk_i);
      chk("rst_no_wb", wb_addr_q.size() - b_wb, 0);
      chk("rst_no_req", req_rise - b_rise, 0);
      chk("rst_idle", busy_o, 0);
      do_flush(0, lat);
      chk("rst_new_wb_count", wb_addr_q.size() - b_wb, 1);
      if (wb_addr_q.size() > b_wb) chk("rst_new_wb_addr", wb_addr_q[b_wb], 12'h224);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
